// File: rtl/video_pkg.sv
// video_pkg -- shared types and default timing for the composite video
// front end, sampled at 4*fsc NTSC (14.318 MHz).
//   SAMPLE_W_C      : signed sample width (also used by loop filter and NCO)
//   *_C constants   : default sync / burst / line timing in sample clocks
//   gate_state_t    : burst gate sequencer states
package video_pkg;

  localparam int SAMPLE_W_C     = 12;

  localparam int SYNC_LO_C      = -1200;
  localparam int SYNC_HI_C      = -900;
  localparam int SYNC_MIN_C     = 40;
  localparam int SYNC_MAX_C     = 100;
  localparam int BURST_DELAY_C  = 8;
  localparam int BURST_LEN_C    = 32;
  localparam int LINE_MIN_C     = 800;
  localparam int LINE_TIMEOUT_C = 1200;
  localparam int LOCK_COUNT_C   = 4;

  typedef enum logic [2:0] {
    SEEK      = 3'd0,
    IN_SYNC   = 3'd1,
    LONG_SYNC = 3'd2,
    BREEZEWAY = 3'd3,
    BURST     = 3'd4,
    HOLDOFF   = 3'd5
  } gate_state_t;

endpackage

// File: rtl/sync_slicer.sv
// sync_slicer -- hysteresis sync comparator plus sync width counter.
//   clk, rst          : sample clock, async active-high reset
//   video_i           : signed composite sample
//   start_i           : first sync sample seen; width restarts at 1
//   count_i           : sequencer is inside a sync pulse; width advances
//   sync_level_o      : sample is below the enter-sync threshold
//   sync_end_o        : sample is at/above the exit-sync threshold
//   width_ok_o        : current width lies within SYNC_MIN..SYNC_MAX
//   width_max_o       : width has reached SYNC_MAX (next low sample overflows)
module sync_slicer
  import video_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_C,
  parameter int SYNC_LO  = SYNC_LO_C,
  parameter int SYNC_HI  = SYNC_HI_C,
  parameter int SYNC_MIN = SYNC_MIN_C,
  parameter int SYNC_MAX = SYNC_MAX_C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] video_i,
  input  logic                       start_i,
  input  logic                       count_i,
  output logic                       sync_level_o,
  output logic                       sync_end_o,
  output logic                       width_ok_o,
  output logic                       width_max_o
);

  localparam int WIDTH_W = $clog2(SYNC_MAX + 2);

  localparam logic signed [SAMPLE_W-1:0] LO_C  = SAMPLE_W'(SYNC_LO);
  localparam logic signed [SAMPLE_W-1:0] HI_C  = SAMPLE_W'(SYNC_HI);
  localparam logic [WIDTH_W-1:0]         MIN_C = WIDTH_W'(SYNC_MIN);
  localparam logic [WIDTH_W-1:0]         MAX_C = WIDTH_W'(SYNC_MAX);
  localparam logic [WIDTH_W-1:0]         ONE_C = WIDTH_W'(1);

  logic [WIDTH_W-1:0] width_q;
  logic [WIDTH_W-1:0] width_d;

  assign sync_level_o = (video_i < LO_C);
  assign sync_end_o   = (video_i >= HI_C);

  // Width stops one past SYNC_MAX so it can never wrap back into range.
  always_comb begin
    width_d = width_q;
    if (start_i) begin
      width_d = ONE_C;
    end else if (count_i && (width_q <= MAX_C)) begin
      width_d = width_q + ONE_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q <= '0;
    end else begin
      width_q <= width_d;
    end
  end

  assign width_ok_o  = (width_q >= MIN_C) && (width_q <= MAX_C);
  assign width_max_o = (width_q >= MAX_C);

endmodule

// File: rtl/burst_gate.sv
// burst_gate -- qualifies horizontal sync by width and spacing and opens the
// colour-burst gate for the chroma PLL loop filter after each valid sync.
//   clk, rst      : sample clock, async active-high reset
//   video_in      : signed composite sample, one per clock
//   burst_active  : gate to the burst-averaging loop filter
//   hsync_pulse   : one-cycle strobe per valid sync
//   line_locked   : LOCK_COUNT consecutive good lines without a timeout
//
// state     | meaning
// SEEK      | waiting for a sample below SYNC_LO
// IN_SYNC   | inside a sync pulse, width being measured
// LONG_SYNC | pulse too wide (vertical broad pulse); wait for it to end
// BREEZEWAY | valid sync ended; delay before the burst
// BURST     | gate open for BURST_LEN cycles
// HOLDOFF   | video ignored until LINE_MIN cycles after sync start
module burst_gate
  import video_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_C,
  parameter int SYNC_LO      = SYNC_LO_C,
  parameter int SYNC_HI      = SYNC_HI_C,
  parameter int SYNC_MIN     = SYNC_MIN_C,
  parameter int SYNC_MAX     = SYNC_MAX_C,
  parameter int BURST_DELAY  = BURST_DELAY_C,
  parameter int BURST_LEN    = BURST_LEN_C,
  parameter int LINE_MIN     = LINE_MIN_C,
  parameter int LINE_TIMEOUT = LINE_TIMEOUT_C,
  parameter int LOCK_COUNT   = LOCK_COUNT_C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] video_in,
  output logic                       burst_active,
  output logic                       hsync_pulse,
  output logic                       line_locked
);

  localparam int TMR_MAX = (BURST_DELAY > BURST_LEN) ? BURST_DELAY : BURST_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int LINE_W  = $clog2(LINE_TIMEOUT + 1);
  localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);

  localparam logic [TMR_W-1:0]  DELAY_C   = TMR_W'(BURST_DELAY);
  localparam logic [TMR_W-1:0]  LEN_M1_C  = TMR_W'(BURST_LEN - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE_C = TMR_W'(1);
  localparam logic [LINE_W-1:0] LMIN_C    = LINE_W'(LINE_MIN);
  localparam logic [LINE_W-1:0] LTO_C     = LINE_W'(LINE_TIMEOUT);
  localparam logic [LINE_W-1:0] LINE_ONE_C = LINE_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] LOCK_M1_C = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE_C = GOOD_W'(1);

  gate_state_t        state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [LINE_W-1:0]  line_cnt_q;
  logic [GOOD_W-1:0]  good_cnt_q;
  logic               burst_q;
  logic               hsync_q;
  logic               locked_q;

  logic sync_level;
  logic sync_end;
  logic width_ok;
  logic width_max;
  logic sync_start;
  logic timeout;

  sync_slicer #(
    .SAMPLE_W (SAMPLE_W),
    .SYNC_LO  (SYNC_LO),
    .SYNC_HI  (SYNC_HI),
    .SYNC_MIN (SYNC_MIN),
    .SYNC_MAX (SYNC_MAX)
  ) u_slicer (
    .clk          (clk),
    .rst          (rst),
    .video_i      (video_in),
    .start_i      (sync_start),
    .count_i      (state_q == IN_SYNC),
    .sync_level_o (sync_level),
    .sync_end_o   (sync_end),
    .width_ok_o   (width_ok),
    .width_max_o  (width_max)
  );

  assign sync_start = (state_q == SEEK) && sync_level;
  // A sync starting on the timeout cycle restarts the line count, so it
  // takes precedence over the timeout.
  assign timeout    = (line_cnt_q == LTO_C) && !sync_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEEK;
      tmr_q      <= '0;
      line_cnt_q <= '0;
      good_cnt_q <= '0;
      burst_q    <= 1'b0;
      hsync_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      hsync_q <= 1'b0;

      if (sync_start) begin
        line_cnt_q <= '0;
      end else if (line_cnt_q != LTO_C) begin
        line_cnt_q <= line_cnt_q + LINE_ONE_C;
      end

      if (timeout) begin
        locked_q   <= 1'b0;
        good_cnt_q <= '0;
      end

      case (state_q)
        SEEK: begin
          if (sync_level) begin
            state_q <= IN_SYNC;
          end
        end
        IN_SYNC: begin
          if (sync_end) begin
            if (width_ok) begin
              state_q <= BREEZEWAY;
              tmr_q   <= DELAY_C;
              hsync_q <= 1'b1;
              if (good_cnt_q != LOCK_C) begin
                good_cnt_q <= good_cnt_q + GOOD_ONE_C;
              end
              if (good_cnt_q >= LOCK_M1_C) begin
                locked_q <= 1'b1;
              end
            end else begin
              state_q <= SEEK;
            end
          end else if (width_max) begin
            state_q <= LONG_SYNC;
          end
        end
        LONG_SYNC: begin
          if (sync_end) begin
            state_q <= SEEK;
          end
        end
        // Timer loaded with BURST_DELAY expires one cycle late on purpose:
        // the gate register then rises exactly BURST_DELAY+1 edges after
        // the trailing edge of sync.
        BREEZEWAY: begin
          if (tmr_q == '0) begin
            state_q <= BURST;
            burst_q <= 1'b1;
            tmr_q   <= LEN_M1_C;
          end else begin
            tmr_q <= tmr_q - TMR_ONE_C;
          end
        end
        BURST: begin
          if (tmr_q == '0) begin
            state_q <= HOLDOFF;
            burst_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - TMR_ONE_C;
          end
        end
        HOLDOFF: begin
          if ((line_cnt_q >= LMIN_C) || timeout) begin
            state_q <= SEEK;
          end
        end
        default: begin
          state_q <= SEEK;
        end
      endcase
    end
  end

  assign burst_active = burst_q;
  assign hsync_pulse  = hsync_q;
  assign line_locked  = locked_q;

endmodule

// File: tb/tb_burst_gate.sv
// tb_burst_gate -- directed bench for burst_gate with default NTSC timing.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_burst_gate;
  import video_pkg::*;

  localparam logic signed [11:0] V_SYNC  = -12'sd1500;
  localparam logic signed [11:0] V_MID   = -12'sd1000;
  localparam logic signed [11:0] V_BLANK = 12'sd0;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] video_in;
  logic               burst_active;
  logic               hsync_pulse;
  logic               line_locked;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int hs_cnt = 0, hs_last = -1;
  int gate_cnt = 0, b_start = -1, b_run = 0, b_len = -1;
  int lock_rise = -1, lock_fall = -1;
  logic burst_prev = 1'b0, lock_prev = 1'b0, saw_long = 1'b0;

  int t_start, t_end;

  burst_gate dut (
    .clk          (clk),
    .rst          (rst),
    .video_in     (video_in),
    .burst_active (burst_active),
    .hsync_pulse  (hsync_pulse),
    .line_locked  (line_locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (hsync_pulse) begin
      hs_cnt++;
      hs_last = cyc;
    end
    if (burst_active && !burst_prev) begin
      gate_cnt++;
      b_start = cyc;
      b_run   = 0;
    end
    if (burst_active) b_run++;
    else if (burst_prev) b_len = b_run;
    if (line_locked && !lock_prev) lock_rise = cyc;
    if (!line_locked && lock_prev) lock_fall = cyc;
    if (dut.state_q == LONG_SYNC) saw_long = 1'b1;
    burst_prev = burst_active;
    lock_prev  = line_locked;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // w_low sync samples, then w_mid samples between the thresholds, then
  // blanking until period samples have been sent. t_start is the edge that
  // samples the first sync sample, t_end the edge that samples the first
  // blanking sample.
  task automatic send_pulse(input int w_low, input int w_mid, input int period);
    for (int i = 0; i < period; i++) begin
      @(negedge clk);
      if (i == 0) t_start = cyc + 1;
      if (i == w_low + w_mid) t_end = cyc + 1;
      if (i < w_low) video_in = V_SYNC;
      else if (i < w_low + w_mid) video_in = V_MID;
      else video_in = V_BLANK;
    end
  endtask

  task automatic check_gate(input string tag);
    check_val({tag, "_hs"}, hs_last, t_end);
    check_val({tag, "_start"}, b_start, t_end + 9);
    check_val({tag, "_len"}, b_len, 32);
  endtask

  initial begin
    int hs0, g0, t_a;
    rst      = 1'b1;
    video_in = V_BLANK;
    repeat (3) @(negedge clk);
    check_val("rst_burst", burst_active, 0);
    check_val("rst_hsync", hsync_pulse, 0);
    check_val("rst_lock", line_locked, 0);
    check_val("rst_state", 32'(dut.state_q), 32'(SEEK));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // clean lines: lock on the 4th
    for (int i = 1; i <= 4; i++) begin
      send_pulse(67, 0, 910);
      check_gate($sformatf("clean%0d", i));
      if (i == 3) check_val("lock_l3", line_locked, 0);
    end
    check_val("lock_l4", line_locked, 1);
    check_val("lock_rise", lock_rise, t_end);
    check_val("clean_hs_cnt", hs_cnt, 4);

    // mid-threshold samples inside sync hold the pulse open
    send_pulse(60, 7, 910);
    check_gate("hyst");

    // glitch after holdoff
    send_pulse(67, 0, 820);
    hs0 = hs_cnt; g0 = gate_cnt;
    send_pulse(10, 0, 90);
    check_val("glitch_hs", hs_cnt, hs0);
    check_val("glitch_gate", gate_cnt, g0);
    check_val("glitch_lock", line_locked, 1);
    send_pulse(67, 0, 910);
    check_gate("post_glitch");

    // broad pulse
    hs0 = hs_cnt; g0 = gate_cnt; saw_long = 1'b0;
    send_pulse(250, 0, 910);
    check_val("broad_long", saw_long, 1);
    check_val("broad_hs", hs_cnt, hs0);
    check_val("broad_gate", gate_cnt, g0);
    send_pulse(67, 0, 910);
    check_gate("post_broad");
    check_val("broad_lock", line_locked, 1);

    // pulses at half-line spacing: only every second one is accepted
    g0 = gate_cnt;
    send_pulse(67, 0, 455);
    t_a = t_end;
    send_pulse(67, 0, 455);
    check_val("eq_b_ignored", hs_last, t_a);
    send_pulse(67, 0, 455);
    check_gate("eq_c");
    send_pulse(67, 0, 455);
    check_val("eq_gates", gate_cnt - g0, 2);

    // loss of sync then relock
    check_val("pre_to_lock", line_locked, 1);
    send_pulse(67, 0, 1400);
    check_val("to_fall", lock_fall, t_start + 1201);
    check_val("to_lock", line_locked, 0);
    for (int i = 1; i <= 4; i++) begin
      send_pulse(67, 0, 910);
      if (i == 3) check_val("relock_l3", line_locked, 0);
    end
    check_val("relock_l4", line_locked, 1);
    check_val("relock_rise", lock_rise, t_end);

    // reset in the middle of a gate
    send_pulse(67, 0, 68);
    repeat (24) @(posedge clk);
    #1;
    check_val("mid_gate_on", burst_active, 1);
    #1 rst = 1'b1;
    #1;
    check_val("rst_async_burst", burst_active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_rel_state", 32'(dut.state_q), 32'(SEEK));
    check_val("rst_rel_lock", line_locked, 0);
    check_val("rst_partial_len", b_len, 14);
    send_pulse(67, 0, 910);
    check_gate("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/burst_gate.md
# burst_gate

Generates the colour-burst gate that drives the burst-averaging PI loop filter in the chroma PLL. Watches the digitised composite video stream and qualifies horizontal sync pulses by width and spacing. After each valid sync it asserts `burst_active` for a fixed window over the burst. It also reports sync health (`hsync_pulse`, `line_locked`) to the rest of the decoder.

## Interface
- `SAMPLE_W`, default 12: width of the signed video sample.
- `SYNC_LO`, default -1200: enter-sync threshold; a sample `< SYNC_LO` counts as sync level.
- `SYNC_HI`, default -900: exit-sync threshold; a sample `>= SYNC_HI` counts as end of sync (hysteresis).
- `SYNC_MIN`, default 40: minimum valid sync width, in cycles.
- `SYNC_MAX`, default 100: maximum valid sync width, in cycles.
- `BURST_DELAY`, default 8: cycles from sync trailing edge to burst gate start.
- `BURST_LEN`, default 32: gate length in cycles, 1..127.
- `LINE_MIN`, default 800: holdoff from sync start; sync-level samples before this count are ignored.
- `LINE_TIMEOUT`, default 1200: cycles without a valid sync before lock is dropped.
- `LOCK_COUNT`, default 4: consecutive valid lines needed to declare lock.

Ports:
- `clk`, in, 1: sample clock; one sample per cycle.
- `rst`, in, 1: reset, asynchronous, active-high.
- `video_in`, in, `SAMPLE_W` (signed): composite sample.
- `burst_active`, out, 1: gate to the loop filter.
- `hsync_pulse`, out, 1: one-cycle strobe per valid sync.
- `line_locked`, out, 1: sync lock status.

## Operation
States and transitions:
- SEEK: go to IN_SYNC on `video_in < SYNC_LO`. On entry to IN_SYNC, `width` = 1 and `line_cnt` = 0.
- IN_SYNC: `width` increments each cycle.
  - On `video_in >= SYNC_HI`: if `SYNC_MIN <= width <= SYNC_MAX`, go to BREEZEWAY; otherwise (glitch) go to SEEK.
  - If `width` would exceed `SYNC_MAX` while still low, go to LONG_SYNC.
  - Samples between the two thresholds hold the state.
- LONG_SYNC (vertical broad pulses): no gate, no `hsync_pulse`. Go to SEEK on `video_in >= SYNC_HI`.
- BREEZEWAY: count `BURST_DELAY` cycles, then go to BURST.
- BURST: `burst_active` = 1 for exactly `BURST_LEN` cycles, then go to HOLDOFF.
- HOLDOFF: ignore video. When `line_cnt >= LINE_MIN`, go to SEEK. This rejects half-line equalising pulses.

Counters and status:
- `line_cnt`: free-running, saturates at `LINE_TIMEOUT`, and resets to 0 on every SEEK→IN_SYNC entry.
- Timeout: `line_cnt == LINE_TIMEOUT` clears `line_locked` and the good-line counter. If it occurs in HOLDOFF, force SEEK.
- Good-line counter increments on each valid sync and saturates at `LOCK_COUNT`. Reaching `LOCK_COUNT` sets `line_locked`.
- An invalid sync (glitch or LONG_SYNC) does not reset the good-line counter.
- Gate generation does not depend on lock.

## Timing
- All outputs are registered. Reset values: `burst_active` = 0, `hsync_pulse` = 0, `line_locked` = 0, state = SEEK, all counters 0.
- Let edge t be the edge at which IN_SYNC samples `video_in >= SYNC_HI` with a valid width. Then:
  - `hsync_pulse` is high for the single cycle after edge t.
  - `burst_active` is high after edges t+`BURST_DELAY`+1 through t+`BURST_DELAY`+`BURST_LEN`.
- `burst_active` is low for at least one cycle between gates. The loop filter depends on this gap to latch its sum.
- `line_locked` rises in the same cycle as the `LOCK_COUNT`-th `hsync_pulse`. It falls the cycle after `line_cnt` reaches `LINE_TIMEOUT`.
- `rst` mid-gate: `burst_active` drops immediately (asynchronous). Any partial burst is discarded.
- Simultaneous timeout and valid sync in the same cycle: the sync wins, because the counter restarts on the SEEK→IN_SYNC entry.

## Structure
- A shared package `video_pkg` holds:
  - the `gate_state_t` enum;
  - default timing constants for 4·fsc NTSC;
  - the sample width.
  The loop filter and NCO reuse the width from this package.
- One natural sub-module is `sync_slicer`, containing the hysteresis comparator and width counter. It outputs `sync_level`, `sync_end` and `width_ok`.

## Test plan
- Clean NTSC lines with 67-cycle sync and 910-cycle period → 32-cycle gate starting 9 cycles after the trailing edge. `line_locked` = 1 on the 4th line.
- 10-cycle negative glitch mid-line, after holdoff → no `hsync_pulse`, no gate; lock is retained.
- 250-cycle broad pulse → LONG_SYNC; no gate; the next normal sync gates correctly.
- Equalising pulses at 455-cycle spacing → only pulses at least `LINE_MIN` apart produce gates.
- Video held at blanking for 1300 cycles → `line_locked` drops at cycle 1200 (timeout); relock after 4 good lines.
- `rst` asserted at gate cycle 15 → `burst_active` = 0 immediately; FSM is in SEEK after release.
